// File: rtl/inst_mem_loader.sv
// Instruction memory with a byte-serial program-load port; fetch returns NOP while a load runs.
// Define INST_MEM_LOADER_CHECKSUM_EN to append an XOR checksum byte to every program load.
module inst_mem_loader #(
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] instruction,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  output logic              load_ready,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_error
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    COMMIT,
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    CHECK,
    CLEAR,
`endif
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [DATA_W-1:0] instruction_q, instruction_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [PTR_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              accept;

`ifdef INST_MEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  logic       error_q, error_d;
  assign load_error = error_q;
`else
  assign load_error = 1'b0;
`endif

  assign instruction = instruction_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    mem_we     = 1'b0;
    mem_waddr  = ptr_q;
    mem_wdata  = word_q;
    load_busy  = (state_q != IDLE);
    load_done  = (state_q == DONE);
    load_ready = (state_q == RECV);
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
    error_d    = error_q;
    load_ready = (state_q == RECV) || (state_q == CHECK);
`endif
    accept = load_valid && load_ready;

    unique case (state_q)
      IDLE: ;
      RECV: begin
        if (accept) begin
          word_d = {word_q[DATA_W-9:0], load_byte};
          cnt_d  = cnt_q + 2'd1;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ load_byte;
`endif
          if (cnt_q == 2'd3) state_d = COMMIT;
        end
      end
      COMMIT: begin
        mem_we = 1'b1;
        cnt_d  = 2'd0;
        if (ptr_q == LAST_PTR) begin
          ptr_d = '0;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end else begin
          ptr_d   = ptr_q + 1'b1;
          state_d = RECV;
        end
      end
`ifdef INST_MEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (accept) begin
          error_d = (load_byte != csum_q);
          state_d = (load_byte != csum_q) ? CLEAR : DONE;
        end
      end
      // A bad image is wiped one word per cycle so no corrupt program can run.
      CLEAR: begin
        mem_we    = 1'b1;
        mem_wdata = '0;
        ptr_d     = ptr_q + 1'b1;
        if (ptr_q == LAST_PTR) begin
          ptr_d   = '0;
          state_d = DONE;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A new load_start wins over anything in flight, including a pending commit.
    if (load_start) begin
      state_d = RECV;
      ptr_d   = '0;
      cnt_d   = 2'd0;
      word_d  = '0;
      mem_we  = 1'b0;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
      csum_d  = 8'h00;
      error_d = 1'b0;
`endif
    end

    instruction_d = '0;
    if (!load_busy && (int'(address) < DEPTH)) instruction_d = mem_q[PTR_W'(address)];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q       <= IDLE;
      ptr_q         <= '0;
      cnt_q         <= 2'd0;
      word_q        <= '0;
      instruction_q <= '0;
      // NOTE: the memory is cleared by reset, so it is built from flops rather than an inferred RAM.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
      csum_q        <= 8'h00;
      error_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      word_q        <= word_d;
      instruction_q <= instruction_d;
      if (mem_we) mem_q[mem_waddr] <= mem_wdata;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
      csum_q        <= csum_d;
      error_q       <= error_d;
`endif
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed self-checking bench for inst_mem_loader (default build and INST_MEM_LOADER_CHECKSUM_EN).
module tb_inst_mem_loader;

  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] instruction;
  logic              load_start;
  logic              load_valid;
  logic [7:0]        load_byte;
  logic              load_ready;
  logic              load_busy;
  logic              load_done;
  logic              load_error;

  int n_cmp    = 0;
  int n_bad    = 0;
  int done_cnt = 0;

  logic [31:0] img [8];

  inst_mem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .address     (address),
    .instruction (instruction),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_byte   (load_byte),
    .load_ready  (load_ready),
    .load_busy   (load_busy),
    .load_done   (load_done),
    .load_error  (load_error)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (load_done === 1'b1) done_cnt++;
  endtask

  function automatic logic [7:0] img_csum();
    logic [7:0] c;
    c = 8'h00;
    for (int w = 0; w < 8; w++) c = c ^ img[w][31:24] ^ img[w][23:16] ^ img[w][15:8] ^ img[w][7:0];
    return c;
  endfunction

  task automatic set_default_img();
    img[0] = 32'h1A000005; img[1] = 32'h00A00093; img[2] = 32'h00100113; img[3] = 32'h002081B3;
    img[4] = 32'hFE000EE3; img[5] = 32'h12345678; img[6] = 32'hDEADBEEF; img[7] = 32'h02120000;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    k = 0;
    load_valid = 1'b0;
    while (load_ready !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    n_cmp++;
    if (load_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_timeout: load_ready=%b expected 1", load_ready);
    end
    load_valid = 1'b1;
    load_byte  = b;
    tick();
    load_valid = 1'b0;
    load_byte  = 8'h00;
  endtask

  // Sends all 32 image bytes; optionally checks the COMMIT cycle after each word.
  task automatic send_image(input bit chk_commit);
    for (int w = 0; w < 8; w++) begin
      for (int b = 0; b < 4; b++) begin
        send_byte(img[w][31-8*b -: 8]);
        if (chk_commit && b == 3) begin
          n_cmp++;
          if (load_ready !== 1'b0 || instruction !== 32'h0 || load_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL commit_cycle w%0d: ready=%b instr=%h busy=%b expected 0/00000000/1",
                     w, load_ready, instruction, load_busy);
          end
        end
      end
    end
  endtask

  task automatic finish_load(input logic [7:0] csum, output int cycles);
    cycles = 0;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    send_byte(csum);
`endif
    while (load_done !== 1'b1 && cycles < 40) begin
      tick();
      cycles++;
    end
    n_cmp++;
    if (load_done !== 1'b1) begin
      n_bad++;
      $display("FAIL done_timeout: load_done=%b expected 1 (csum byte %h)", load_done, csum);
    end
    tick();
    n_cmp++;
    if (load_done !== 1'b0 || load_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL done_single_pulse: done=%b busy=%b expected 0/0", load_done, load_busy);
    end
  endtask

  task automatic read_all(input string name);
    for (int a = 0; a < 8; a++) begin
      address = ADDR_W'(a);
      tick();
      n_cmp++;
      if (instruction !== img[a]) begin
        n_bad++;
        $display("FAIL %s addr %0d: got %h expected %h", name, a, instruction, img[a]);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_byte = 8'h00; address = '0;
    repeat (3) tick();
    reset_n = 1'b1;
    n_cmp++;
    if (load_ready !== 1'b0 || load_busy !== 1'b0 || load_done !== 1'b0 || load_error !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_flags: ready=%b busy=%b done=%b error=%b expected 0000",
               load_ready, load_busy, load_done, load_error);
    end
    n_cmp++;
    if (instruction !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_instr: got %h expected 00000000", instruction);
    end
    for (int w = 0; w < 8; w++) img[w] = 32'h0;
    read_all("reset_mem");
  endtask

  task automatic test_back_to_back();
    int d0, cyc;
    set_default_img();
    d0 = done_cnt;
    address = 3'd3;
    pulse_start();
    n_cmp++;
    if (load_busy !== 1'b1 || load_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL start_state: busy=%b ready=%b expected 1/1", load_busy, load_ready);
    end
    send_image(1'b1);
    finish_load(img_csum(), cyc);
`ifndef INST_MEM_LOADER_CHECKSUM_EN
    n_cmp++;
    if (cyc !== 1) begin
      n_bad++;
      $display("FAIL commit_to_done: got %0d cycles expected 1", cyc);
    end
`endif
    n_cmp++;
    if (done_cnt - d0 !== 1) begin
      n_bad++;
      $display("FAIL done_count_b2b: got %0d expected 1", done_cnt - d0);
    end
    n_cmp++;
    if (instruction !== 32'h0) begin
      n_bad++;
      $display("FAIL fetch_during_done: got %h expected 00000000", instruction);
    end
    tick();
    n_cmp++;
    if (instruction !== 32'h002081B3) begin
      n_bad++;
      $display("FAIL first_fetch_addr3: got %h expected 002081b3", instruction);
    end
    address = 3'd0;
    tick();
    n_cmp++;
    if (instruction !== 32'h1A000005) begin
      n_bad++;
      $display("FAIL fetch_addr0: got %h expected 1a000005", instruction);
    end
    read_all("b2b_mem");
  endtask

  task automatic test_abort();
    int d0, cyc;
    set_default_img();
    d0 = done_cnt;
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i));
    img[0] = 32'h00500293; img[1] = 32'h00628333; img[2] = 32'h40530433; img[3] = 32'h0082A023;
    img[4] = 32'h0002A483; img[5] = 32'h00940463; img[6] = 32'hFE5FF06F; img[7] = 32'h00000073;
    pulse_start();
    n_cmp++;
    if (done_cnt !== d0 || load_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_no_done: done_delta=%0d busy=%b expected 0/1", done_cnt - d0, load_busy);
    end
    send_image(1'b0);
    finish_load(img_csum(), cyc);
    n_cmp++;
    if (done_cnt - d0 !== 1) begin
      n_bad++;
      $display("FAIL done_count_abort: got %0d expected 1", done_cnt - d0);
    end
    read_all("abort_mem");
  endtask

  task automatic test_toggle_valid();
    int k, cyc;
    bit tog, rdy;
    for (int w = 0; w < 8; w++)
      img[w] = {8'(4*w+1), 8'(4*w+2), 8'(4*w+3), 8'(4*w+4)};
    load_valid = 1'b1; load_byte = 8'hFF;
    tick();
    load_start = 1'b1; load_byte = 8'hFE;
    tick();
    load_start = 1'b0;
    k = 0; cyc = 0; tog = 1'b1;
    while (k < 32 && cyc < 200) begin
      rdy = (load_ready === 1'b1);
      if (rdy) begin
        load_valid = tog;
        load_byte  = 8'(k + 1);
      end else begin
        load_valid = 1'b1;
        load_byte  = 8'hEE;
      end
      tick();
      cyc++;
      if (rdy && tog) k++;
      tog = !tog;
    end
    load_valid = 1'b0;
    n_cmp++;
    if (k !== 32) begin
      n_bad++;
      $display("FAIL toggle_bytes_sent: got %0d expected 32", k);
    end
    finish_load(8'h20, cyc);
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    n_cmp++;
    if (cyc !== 0) begin
      n_bad++;
      $display("FAIL csum_match_latency: got %0d cycles expected 0", cyc);
    end
`endif
    n_cmp++;
    if (load_error !== 1'b0) begin
      n_bad++;
      $display("FAIL toggle_error: got %b expected 0", load_error);
    end
    read_all("toggle_mem");
  endtask

`ifdef INST_MEM_LOADER_CHECKSUM_EN
  task automatic test_checksum_bad();
    int cyc;
    pulse_start();
    send_image(1'b0);
    finish_load(8'h00, cyc);
    n_cmp++;
    if (cyc !== DEPTH) begin
      n_bad++;
      $display("FAIL clear_cycles: got %0d expected %0d", cyc, DEPTH);
    end
    n_cmp++;
    if (load_error !== 1'b1) begin
      n_bad++;
      $display("FAIL csum_error_set: got %b expected 1", load_error);
    end
    for (int w = 0; w < 8; w++) img[w] = 32'h0;
    read_all("cleared_mem");
    n_cmp++;
    if (load_error !== 1'b1) begin
      n_bad++;
      $display("FAIL csum_error_hold: got %b expected 1", load_error);
    end
    pulse_start();
    n_cmp++;
    if (load_error !== 1'b0) begin
      n_bad++;
      $display("FAIL csum_error_clear: got %b expected 0", load_error);
    end
  endtask
`endif

  task automatic test_reset_midload();
    int d0, cyc;
    set_default_img();
    pulse_start();
    send_image(1'b0);
    finish_load(img_csum(), cyc);
    read_all("preload_mem");
    d0 = done_cnt;
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(8'h55);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n_cmp++;
    if (load_ready !== 1'b0 || load_busy !== 1'b0 || load_error !== 1'b0 || done_cnt !== d0) begin
      n_bad++;
      $display("FAIL midload_reset_flags: ready=%b busy=%b error=%b done_delta=%0d expected 0/0/0/0",
               load_ready, load_busy, load_error, done_cnt - d0);
    end
    for (int w = 0; w < 8; w++) img[w] = 32'h0;
    read_all("midload_reset_mem");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_abort();
    test_toggle_valid();
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    test_checksum_bad();
`endif
    test_reset_midload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
Instruction memory that answers the processor's fetch port: it takes `address` and returns `instruction`. It also has a byte-serial program-load port, so a host/debug bridge can write a new program at runtime without resynthesis. While a load is in progress the fetch port returns NOP (0x00000000), so the processor idles safely.

Parameters:
- ADDR_W, 3, fetch address width; matches processor `address`.
- DEPTH, 8, number of 32-bit words stored; must be ≤ 2**ADDR_W.
- DATA_W, 32, instruction width; fixed at 32 (4 bytes per word).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  synchronous reset, active-low.
- address  input  ADDR_W  fetch address from processor.
- instruction  output  DATA_W  registered fetch data.
- load_start  input  1  single-cycle pulse; begins a program load at word 0.
- load_valid  input  1  load_byte is valid this cycle.
- load_byte  input  8  program byte, big-endian within each word (byte 0 = bits 31:24).
- load_ready  output  1  block accepts load_byte this cycle.
- load_busy  output  1  load in progress; fetch returns NOP.
- load_done  output  1  single-cycle pulse when the load completes.
- load_error  output  1  checksum mismatch flag (see Optional Feature).

Behaviour:
- One clock. Reset is synchronous and active-low (reset_n sampled on rising clk).
- Reset values:
  - all DEPTH words = 0x00000000
  - instruction = 0
  - load_ready = 0, load_busy = 0, load_done = 0, load_error = 0
  - FSM = IDLE; byte counter = 0; word pointer = 0
- Fetch:
  - Latency 1: instruction <= mem[address] on every clk.
  - address ≥ DEPTH returns 0.
  - When load_busy = 1, instruction <= 0 regardless of address.
- FSM states: IDLE, RECV, COMMIT, (CHECK), DONE.
  - IDLE: load_ready = 0. load_start → RECV; word pointer = 0, byte counter = 0.
  - RECV: load_ready = 1. Byte accepted only when load_valid & load_ready; it shifts into the word assembly register and byte counter +1. On the 4th byte → COMMIT.
  - COMMIT (1 cycle): load_ready = 0; mem[word pointer] <= assembled word; pointer +1. If pointer was DEPTH−1 → DONE (or CHECK when enabled), else → RECV with byte counter = 0.
  - DONE (1 cycle): load_done = 1, load_busy falls the next cycle → IDLE.
- load_busy = 1 in every state except IDLE.
- Boundary conditions:
  - load_start while not IDLE restarts the load: pointer = 0, byte counter = 0, partial word discarded, load_error cleared. Words already committed stay until overwritten.
  - load_valid in IDLE or COMMIT: ignored; nothing is written.
  - load_start and load_valid in the same IDLE cycle: the byte is ignored.
  - Fetch during COMMIT still returns 0.
  - The first fetch after load_done returns new contents. Old and new words never mix in instruction.
  - Reset mid-load: everything returns to reset values, memory included.
- Pointer and byte counter widths: clog2(DEPTH) and 2 bits. No wrap beyond DEPTH; the load ends there.

Optional Feature:
- Macro: INST_MEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the final COMMIT the FSM enters CHECK with load_ready = 1.
  - It accepts one more byte, compared with the XOR of all 4*DEPTH program bytes.
  - load_error <= (mismatch); it holds until the next load_start or reset.
  - On mismatch, all words are cleared to 0 before DONE (takes DEPTH cycles; load_busy stays 1).
  - load_done pulses in both the match and mismatch cases.
- Undefined: no CHECK state, no extra byte, load_error tied 0.

Test Plan:
- Reset, then address = 0..7 → instruction = 0x00000000 on each following cycle; load_ready = 0, load_busy = 0.
- load_start, then 32 bytes forming words 0x1A000005 (word 0) … 0x2120000 (word 7), sent back-to-back → load_ready drops one cycle after every 4th byte, load_done pulses once. Afterwards address = 0 → 0x1A000005 one cycle later.
- Mid-load (after 6 bytes) pulse load_start again, then send a full 32-byte image → memory holds only the second image; no load_done for the aborted load.
- During load, processor holds address = 3 → instruction = 0 throughout; address = 3 after load_done → loaded word 3.
- load_valid toggling 1/0 each cycle with bytes 0x01..0x20 → words 0x01020304 … 0x1D1E1F20 stored; bytes presented in IDLE or COMMIT are dropped.
- CHECKSUM_EN: bytes 0x01..0x20 plus checksum 0x20 → load_error = 0, data kept. Same image with checksum 0x00 → load_error = 1, all words read 0.
